// File: rtl/shift_seq_pkg.sv
// Shared types for the multi-cycle shift engine.
//   state_t : controller states (IDLE, SHIFT, DONE)
//   dir_t   : shift direction encoding (0 = left, 1 = right)
//   is_pow2 : elaboration-time helper used to validate the data width
package shift_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One shift stage of the sequencer: shifts data_i by 2^idx_i when en_i is
// high, otherwise passes it through. The stride is selected by idx_i, so the
// controller reuses this single stage for every bit of the shift amount.
//   data_i  : N-bit operand
//   idx_i   : stage index k, stride is 2^k
//   en_i    : apply the shift this stage (amount bit k)
//   dir_i   : DIR_LEFT / DIR_RIGHT
//   arith_i : sign-fill on right shift, ignored for left shift
//   data_o  : N-bit result
module shift_stage
    import shift_seq_pkg::*;
#(
    parameter  int N  = 8,
    localparam int AW = $clog2(N)
) (
    input  logic [N-1:0]  data_i,
    input  logic [AW-1:0] idx_i,
    input  logic          en_i,
    input  dir_t          dir_i,
    input  logic          arith_i,
    output logic [N-1:0]  data_o
);

    localparam int SW = AW + 1;

    logic [SW-1:0]       stride;
    logic signed [N-1:0] data_s;

    assign stride = SW'(1) << idx_i;
    // Signed view so >>> replicates the MSB of the current value.
    assign data_s = data_i;

    always_comb begin
        data_o = data_i;
        if (en_i) begin
            if (dir_i == DIR_LEFT) begin
                data_o = data_i << stride;
            end else if (arith_i) begin
                data_o = data_s >>> stride;
            end else begin
                data_o = data_i >> stride;
            end
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle barrel shifter with valid/ready handshakes on both sides.
// Resolves one bit of the shift amount per clock through a single shift
// stage, giving a fixed latency of AW cycles with a shallow logic path.
//   clk, rst   : clock, synchronous active-high reset
//   up_*       : request side (valid/ready, data, amount, direction, arith)
//   down_*     : result side (valid/ready, data)
// up_ready and down_valid are decoded from state only; down_data is the
// data register itself.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter  int N  = 8,
    localparam int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [N-1:0]  up_data,
    input  logic [AW-1:0] up_amt,
    input  logic          up_dir,
    input  logic          up_arith,
    output logic          down_valid,
    input  logic          down_ready,
    output logic [N-1:0]  down_data
);

    if (N < 2 || !is_pow2(N)) begin : g_bad_width
        $error("shift_sequencer: N must be a power of two and >= 2");
    end

    localparam logic [AW-1:0] LAST_STAGE = AW'(AW - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q,   cnt_d;
    logic [AW-1:0] amt_q,   amt_d;
    logic [N-1:0]  data_q,  data_d;
    dir_t          dir_q,   dir_d;
    logic          arith_q, arith_d;

    logic          stage_en;
    logic [N-1:0]  stage_out;

    // Amount bit for the current stage, selected with a mask to keep the
    // index arithmetic at the counter width.
    assign stage_en = |(amt_q & (AW'(1) << cnt_q));

    shift_stage #(
        .N (N)
    ) u_stage (
        .data_i  (data_q),
        .idx_i   (cnt_q),
        .en_i    (stage_en),
        .dir_i   (dir_q),
        .arith_i (arith_q),
        .data_o  (stage_out)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        amt_d   = amt_q;
        data_d  = data_q;
        dir_d   = dir_q;
        arith_d = arith_q;
        case (state_q)
            IDLE: begin
                if (up_valid) begin
                    data_d  = up_data;
                    amt_d   = up_amt;
                    dir_d   = dir_t'(up_dir);
                    arith_d = up_arith;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Every stage runs, even with a zero amount, so latency is fixed.
                data_d = stage_out;
                if (cnt_q == LAST_STAGE) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            DONE: begin
                if (down_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            amt_q   <= '0;
            data_q  <= '0;
            dir_q   <= DIR_LEFT;
            arith_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            amt_q   <= amt_d;
            data_q  <= data_d;
            dir_q   <= dir_d;
            arith_q <= arith_d;
        end
    end

    assign up_ready   = (state_q == IDLE);
    assign down_valid = (state_q == DONE);
    assign down_data  = data_q;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

    localparam int N  = 8;
    localparam int AW = 3;

    logic          clk;
    logic          rst;
    logic          up_valid;
    logic          up_ready;
    logic [N-1:0]  up_data;
    logic [AW-1:0] up_amt;
    logic          up_dir;
    logic          up_arith;
    logic          down_valid;
    logic          down_ready;
    logic [N-1:0]  down_data;

    int n_checks = 0;
    int n_fail   = 0;

    shift_sequencer #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_data    (up_data),
        .up_amt     (up_amt),
        .up_dir     (up_dir),
        .up_arith   (up_arith),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .down_data  (down_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the shift as plain arithmetic on the whole operand.
    function automatic logic [N-1:0] model(input logic [N-1:0] a, input int amt,
                                           input logic dir, input logic ar);
        logic signed [N-1:0] s;
        s = a;
        if (!dir) return a << amt;
        if (ar)   return s >>> amt;
        return a >> amt;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_inputs();
        up_data  = N'($urandom);
        up_amt   = AW'($urandom);
        up_dir   = 1'($urandom);
        up_arith = 1'($urandom);
    endtask

    // Issue one request from IDLE, wait for the result, check latency and data.
    task automatic run_op(input string tag, input logic [N-1:0] d, input logic [AW-1:0] a,
                          input logic dir, input logic ar, input logic [N-1:0] exp_c,
                          input bit release_it);
        int lat;
        check({tag, "_up_ready"}, 32'(up_ready), 32'd1);
        up_valid = 1'b1;
        up_data  = d;
        up_amt   = a;
        up_dir   = dir;
        up_arith = ar;
        tick();
        up_valid = 1'b0;
        scramble_inputs();
        lat = 0;
        while (!down_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(AW));
        check({tag, "_data"}, 32'(down_data), 32'(exp_c));
        check({tag, "_model"}, 32'(down_data), 32'(model(d, int'(a), dir, ar)));
        if (release_it) begin
            down_ready = 1'b1;
            tick();
            down_ready = 1'b0;
            check({tag, "_idle_ready"}, 32'(up_ready), 32'd1);
            check({tag, "_idle_valid"}, 32'(down_valid), 32'd0);
        end
    endtask

    initial begin
        int           cyc;
        int           done_ops;
        int           acc_cyc;
        bit           busy;
        bit           pend;
        bit           seen;
        logic [N-1:0] exp_q;
        logic [N-1:0] pd;
        logic [AW-1:0] pa;
        logic         pdir;
        logic         par;
        logic         pre_uv, pre_ur, pre_dv, pre_dr;

        rst        = 1'b1;
        up_valid   = 1'b1;   // handshake during reset must be ignored
        up_data    = 8'hAA;
        up_amt     = 3'd1;
        up_dir     = 1'b0;
        up_arith   = 1'b0;
        down_ready = 1'b0;
        tick();
        tick();
        check("reset_up_ready", 32'(up_ready), 32'd1);
        check("reset_down_valid", 32'(down_valid), 32'd0);
        check("reset_down_data", 32'(down_data), 32'd0);
        up_valid = 1'b0;
        rst = 1'b0;
        tick();
        check("post_reset_up_ready", 32'(up_ready), 32'd1);

        run_op("left3",      8'hB3, 3'd3, 1'b0, 1'b0, 8'h98, 1'b1);
        run_op("rlog3",      8'hB3, 3'd3, 1'b1, 1'b0, 8'h16, 1'b1);
        run_op("rari3",      8'hB3, 3'd3, 1'b1, 1'b1, 8'hF6, 1'b1);
        run_op("rari3_pos",  8'h73, 3'd3, 1'b1, 1'b1, 8'h0E, 1'b1);
        run_op("amt0",       8'hB3, 3'd0, 1'b0, 1'b0, 8'hB3, 1'b1);
        run_op("left7",      8'hB3, 3'd7, 1'b0, 1'b0, 8'h80, 1'b1);
        run_op("rari7",      8'hB3, 3'd7, 1'b1, 1'b1, 8'hFF, 1'b1);

        // Backpressure: hold the result, poke up_valid, then release.
        run_op("bp", 8'hB3, 3'd3, 1'b0, 1'b0, 8'h98, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                up_valid = 1'b1;
                up_data  = 8'h5A;
                up_amt   = 3'd1;
            end
            tick();
            up_valid = 1'b0;
            check("bp_down_valid", 32'(down_valid), 32'd1);
            check("bp_down_data", 32'(down_data), 32'h98);
            check("bp_up_ready", 32'(up_ready), 32'd0);
        end
        down_ready = 1'b1;
        tick();
        down_ready = 1'b0;
        check("bp_release_up_ready", 32'(up_ready), 32'd1);
        check("bp_release_down_valid", 32'(down_valid), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen = seen | down_valid | !up_ready;
        end
        check("bp_pulse_ignored", 32'(seen), 32'd0);

        // Reset on the second SHIFT cycle drops the operation.
        check("rst_mid_ready", 32'(up_ready), 32'd1);
        up_valid = 1'b1;
        up_data  = 8'hB3;
        up_amt   = 3'd3;
        up_dir   = 1'b0;
        up_arith = 1'b0;
        tick();
        up_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_up_ready", 32'(up_ready), 32'd1);
        check("rst_mid_down_valid", 32'(down_valid), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen = seen | down_valid;
        end
        check("rst_mid_no_result", 32'(seen), 32'd0);
        run_op("after_rst", 8'h01, 3'd5, 1'b0, 1'b0, 8'h20, 1'b1);

        // Randomized handshakes on both sides against the arithmetic model.
        cyc      = 0;
        done_ops = 0;
        acc_cyc  = 0;
        busy     = 1'b0;
        pend     = 1'b0;
        exp_q    = '0;
        pd       = '0;
        pa       = '0;
        pdir     = 1'b0;
        par      = 1'b0;
        while (done_ops < 1000 && cyc < 40000) begin
            if (!pend && $urandom_range(0, 3) != 0) begin
                pend = 1'b1;
                pd   = N'($urandom);
                pa   = AW'($urandom_range(0, N - 1));
                pdir = 1'($urandom);
                par  = 1'($urandom);
            end
            up_valid = pend;
            if (pend) begin
                up_data  = pd;
                up_amt   = pa;
                up_dir   = pdir;
                up_arith = par;
            end else begin
                scramble_inputs();
            end
            down_ready = ($urandom_range(0, 2) != 0);
            pre_uv = up_valid;
            pre_ur = up_ready;
            pre_dv = down_valid;
            pre_dr = down_ready;
            tick();
            cyc++;
            if (pre_uv && pre_ur) begin
                exp_q   = model(pd, int'(pa), pdir, par);
                busy    = 1'b1;
                acc_cyc = cyc;
                pend    = 1'b0;
            end
            if (pre_dv && pre_dr) begin
                busy = 1'b0;
                done_ops++;
            end
            check("rand_up_ready", 32'(up_ready), 32'(!busy));
            check("rand_down_valid", 32'(down_valid), 32'(busy && (cyc - acc_cyc) >= AW));
            if (down_valid) begin
                check("rand_down_data", 32'(down_data), 32'(exp_q));
            end
        end
        up_valid   = 1'b0;
        down_ready = 1'b0;
        check("rand_ops_completed", 32'(done_ops), 32'd1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle, parameterized barrel-shift engine with a valid/ready handshake on both sides.
- One operation is data plus amount plus direction plus arithmetic flag. It resolves one bit of the shift amount per clock, so each cycle needs only a single fixed-stride shift stage.
- Sits between a requester (ALU sequencer or testbench driver) and a consumer. It trades latency for a shallow combinational path compared with the single-cycle shift modules in this directory.

Parameters:
- N, 8, data width; must be a power of two, N >= 2 (elaboration-time assertion).
- AW, $clog2(N), shift amount width and number of shift cycles; derived, not overridden.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- up_valid  input  1  request valid.
- up_ready  output  1  engine can accept a request.
- up_data  input  N  operand, unsigned bit vector.
- up_amt  input  AW  shift amount, 0..N-1.
- up_dir  input  1  0 = left, 1 = right.
- up_arith  input  1  1 = arithmetic (sign-fill) on right shift; ignored for left shift.
- down_valid  output  1  result valid.
- down_ready  input  1  consumer accepts result.
- down_data  output  N  shifted result.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- State machine: three states, IDLE, SHIFT and DONE.
  - On rst: state goes to IDLE, stage counter to 0, data register to 0. up_ready = 1 and down_valid = 0 from the first cycle after reset.
  - IDLE: up_ready = 1, down_valid = 0.
  - On up_valid && up_ready at an edge:
    - latch up_data, up_amt, up_dir and up_arith into registers;
    - clear the stage counter;
    - go to SHIFT.
  - SHIFT: up_ready = 0, down_valid = 0.
    - Each edge, stage k (the counter value) shifts the data register by 2^k when amt_reg[k] = 1, otherwise leaves it unchanged. Direction and fill follow the latched dir/arith.
    - Left shift fills with 0. Logical right fills with 0. Arithmetic right replicates the latched MSB of the current register value.
    - Counter increments. After the stage k = AW-1 edge, go to DONE.
  - DONE: down_valid = 1, down_data = data register, up_ready = 0.
    - On down_ready: go to IDLE.
    - While down_ready = 0: down_data and down_valid are held stable.
- Latency and throughput:
  - down_valid rises exactly AW edges after the accepting edge (3 for N = 8).
  - Latency is fixed, with no early exit, including when amount = 0.
  - Throughput is one operation per AW+2 cycles at best. No request is accepted while in SHIFT or DONE.
- No combinational paths:
  - up_ready and down_valid are decoded from state only.
  - up_ready does not depend on down_ready.
  - down_data is registered.
- Arithmetic: all widths are N bits. Bits shifted out are discarded. There is no overflow or carry output.
- Boundary conditions:
  - up_valid asserted in SHIFT or DONE is ignored; the requester holds it.
  - Input changes after acceptance do not affect the operation in flight.
  - rst asserted mid-SHIFT or in DONE aborts the operation: state is IDLE next cycle and the result is dropped.
  - rst has priority over every handshake on the same edge.
  - down_ready high in IDLE or SHIFT has no effect.
  - Amount 0 returns the operand unchanged after AW cycles.

Decomposition:
- Package shift_seq_pkg contains:
  - enum state_t {IDLE, SHIFT, DONE};
  - enum dir_t {DIR_LEFT = 0, DIR_RIGHT = 1}.
- One natural sub-module, shift_stage (combinational), with:
  - inputs: N-bit data, stage index, enable, dir, arith;
  - output: the data shifted by 2^index when enable is high.
- The top level instantiates one shift_stage and feeds its output back into the data register.

Test Plan:
- Reset, then left shift, N=8: up_data=8'hB3, amt=3, dir=0 -> down_valid exactly 3 edges after accept, down_data=8'h98.
- Right logical: 8'hB3, amt=3, dir=1, arith=0 -> 8'h16. Right arithmetic: same with arith=1 -> 8'hF6. Arithmetic on 8'h73, amt=3 -> 8'h0E.
- Amount 0 and amount 7: 8'hB3 amt=0 -> 8'hB3 after 3 cycles. Left amt=7 -> 8'h80. Arithmetic right amt=7 -> 8'hFF.
- Backpressure: hold down_ready=0 for 5 cycles in DONE -> down_valid and down_data=8'h98 stable, up_ready=0, and an up_valid pulse is ignored. Release -> IDLE next cycle, up_ready=1.
- Reset mid-operation: assert rst on the second SHIFT cycle -> next cycle up_ready=1, down_valid=0, no result ever emitted. A following request 8'h01, amt=5, left -> 8'h20.
- Back-to-back with a randomized handshake: 1000 random ops compared against the a<<amt / a>>amt / $signed(a)>>>amt model. Check latency = AW every time and that no request is accepted outside IDLE.
